seq_multiplier_hs: RTL

//   Parametrised shift-add sequential multiplier with valid/ready handshakes on both sides.

---
 rtl/seq_multiplier_hs.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_multiplier_hs.sv
// seq_multiplier_hs
// Shift-add sequential multiplier with valid/ready handshakes on both sides.
// Operands are converted to magnitudes at the accept edge (when signed), the
// unsigned product is built one multiplier bit per enabled edge, and the sign
// is re-applied in a single fix-up step before the product is offered.
// A global enable freezes every register; reset takes priority over enable.

module seq_multiplier_hs #(
   parameter int N     = 32,
   parameter int CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   result,
   output logic             busy
);

   localparam int PW = 2 * N;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_q;
   logic [N-1:0]       mcand_q;
   logic [N-1:0]       mplier_q;
   logic [PW-1:0]      acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_q;
   logic [PW-1:0]      result_q;
   logic               out_valid_q;
   logic               in_ready_q;
   logic               busy_q;

   logic [N-1:0]       mag_a_s;
   logic [N-1:0]       mag_b_s;
   logic               neg_s;
   logic [N:0]         sum_s;
   logic [PW-1:0]      acc_d;
   logic [N-1:0]       mplier_d;
   logic [PW-1:0]      acc_neg_s;

   // Two's-complement magnitude; -2^(N-1) maps to 2^(N-1), which still fits N unsigned bits.
   function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic sgn);
      logic [N-1:0] m;
      if (sgn && v[N-1]) begin
         m = (~v) + N'(1);
      end else begin
         m = v;
      end
      return m;
   endfunction

   // Operand conditioning for the accept edge: magnitudes and the product sign.
   always_comb begin
      mag_a_s = magnitude(in_a, in_signed);
      mag_b_s = magnitude(in_b, in_signed);
      if (in_signed) begin
         neg_s = in_a[N-1] ^ in_b[N-1];
      end else begin
         neg_s = 1'b0;
      end
   end

   // One shift-add step: the (N+1)-bit sum keeps the carry, so {carry, acc} shifts right as a 2N+1-bit value.
   always_comb begin
      if (mplier_q[0]) begin
         sum_s = {1'b0, acc_q[PW-1:N]} + {1'b0, mcand_q};
      end else begin
         sum_s = {1'b0, acc_q[PW-1:N]};
      end
      acc_d     = {sum_s, acc_q[N-1:1]};
      mplier_d  = {1'b0, mplier_q[N-1:1]};
      acc_neg_s = (~acc_q) + PW'(1);
   end

   // Control FSM with datapath and registered handshake outputs; frozen while en is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mcand_q     <= {N{1'b0}};
         mplier_q    <= {N{1'b0}};
         acc_q       <= {PW{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         neg_q       <= 1'b0;
         result_q    <= {PW{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else if (en) begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q    <= mag_a_s;
                  mplier_q   <= mag_b_s;
                  neg_q      <= neg_s;
                  acc_q      <= {PW{1'b0}};
                  cnt_q      <= CNT_W'(N);
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               if (neg_q) begin
                  result_q <= acc_neg_s;
               end else begin
                  result_q <= acc_q;
               end
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

endmodule
